// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
// Imported by the operand comparator and by the scheduler top.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } hz_state_e;

    localparam logic [3:0] REG_PC = 4'd15;

    // The PC operand is always forwarded from fetch, so it never creates a load-use conflict.
    function automatic logic reg_conflict(input logic [3:0] src, input logic [3:0] dst);
        return (src == dst) && (src != REG_PC);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: flags an execute-stage operand that needs the result
// of a load still sitting in the memory stage.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [3:0] ex_rn,
    input  logic [3:0] ex_rs,
    input  logic [3:0] ex_rm,
    input  logic [2:0] ex_use,
    input  logic       mem_valid,
    input  logic       mem_is_load,
    input  logic [3:0] mem_rd,
    output logic       hazard
);

    logic rn_hit;
    logic rs_hit;
    logic rm_hit;

    // ex_use is packed {rm, rs, rn}.
    assign rn_hit = ex_use[0] & reg_conflict(ex_rn, mem_rd);
    assign rs_hit = ex_use[1] & reg_conflict(ex_rs, mem_rd);
    assign rm_hit = ex_use[2] & reg_conflict(ex_rm, mem_rd);

    assign hazard = mem_valid & mem_is_load & (rn_hit | rs_hit | rm_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler: memory-wait holds, branch flushes and load-use
// bubbles, with Mealy outputs and a saturating stall-cycle counter.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ex_rn,
    input  logic [3:0]       ex_rs,
    input  logic [3:0]       ex_rm,
    input  logic [2:0]       ex_use,
    input  logic             mem_valid,
    input  logic             mem_is_load,
    input  logic [3:0]       mem_rd,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             bubble_mem,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam hz_state_e BR_NEXT = (FLUSH_CYCLES == 1) ? RUN : FLUSH;

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [FC_W-1:0]  fcnt_q;
    logic [FC_W-1:0]  fcnt_d;
    logic [CNT_W-1:0] scnt_q;

    logic hazard;
    logic mem_wait;
    logic stall_all;
    logic load_stall;
    logic flush_c;
    logic any_stall;

    hazard_detect u_detect (
        .ex_rn       (ex_rn),
        .ex_rs       (ex_rs),
        .ex_rm       (ex_rm),
        .ex_use      (ex_use),
        .mem_valid   (mem_valid),
        .mem_is_load (mem_is_load),
        .mem_rd      (mem_rd),
        .hazard      (hazard)
    );

    assign mem_wait = mem_req & ~mem_ready;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        stall_all  = 1'b0;
        load_stall = 1'b0;
        flush_c    = 1'b0;

        unique case (state_q)
            RUN, LOAD_STALL: begin
                if (mem_wait) begin
                    stall_all = 1'b1;
                    state_d   = MEM_WAIT;
                end else if (br_taken) begin
                    flush_c = 1'b1;
                    fcnt_d  = FC_LOAD;
                    state_d = BR_NEXT;
                end else if (hazard && state_q == RUN) begin
                    load_stall = 1'b1;
                    state_d    = LOAD_STALL;
                end else begin
                    state_d = RUN;
                end
            end

            MEM_WAIT: begin
                // Execute is frozen while waiting, so a held br_taken is only acted on at ready.
                if (mem_wait) begin
                    stall_all = 1'b1;
                end else if (br_taken) begin
                    flush_c = 1'b1;
                    fcnt_d  = FC_LOAD;
                    state_d = BR_NEXT;
                end else begin
                    state_d = RUN;
                end
            end

            FLUSH: begin
                flush_c = 1'b1;
                if (mem_wait) begin
                    stall_all = 1'b1;
                end else if (br_taken) begin
                    fcnt_d  = FC_LOAD;
                    state_d = BR_NEXT;
                end else begin
                    // The branch cycle itself already flushed once, so leave when the count expires.
                    fcnt_d = fcnt_q - FC_W'(1);
                    if (fcnt_d == '0) begin
                        state_d = RUN;
                    end
                end
            end

            default: begin
                state_d = RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    assign stall_if   = ~rst & (stall_all | load_stall);
    assign stall_id   = ~rst & (stall_all | load_stall);
    assign stall_ex   = ~rst & (stall_all | load_stall);
    assign stall_mem  = ~rst & stall_all;
    assign bubble_mem = ~rst & load_stall;
    assign flush      = ~rst & flush_c;
    assign stall_cnt  = rst ? '0 : scnt_q;

    assign any_stall = stall_if | stall_mem;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (any_stall && scnt_q != '1) begin
                scnt_q <= scnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table from RUN plus
// hand-written multi-cycle sequences (load-use, wait, branch, reset, saturation).
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       ex_rn, ex_rs, ex_rm;
    logic [2:0]       ex_use;
    logic             mem_valid, mem_is_load;
    logic [3:0]       mem_rd;
    logic             mem_req, mem_ready, br_taken;
    logic             stall_if, stall_id, stall_ex, stall_mem, bubble_mem, flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [5:0]       outs;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_rn       (ex_rn),
        .ex_rs       (ex_rs),
        .ex_rm       (ex_rm),
        .ex_use      (ex_use),
        .mem_valid   (mem_valid),
        .mem_is_load (mem_is_load),
        .mem_rd      (mem_rd),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .br_taken    (br_taken),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .stall_ex    (stall_ex),
        .stall_mem   (stall_mem),
        .bubble_mem  (bubble_mem),
        .flush       (flush),
        .stall_cnt   (stall_cnt)
    );

    // {stall_if, stall_id, stall_ex, stall_mem, bubble_mem, flush}
    assign outs = {stall_if, stall_id, stall_ex, stall_mem, bubble_mem, flush};

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_LOAD  = 6'b111010;
    localparam logic [5:0] O_WAIT  = 6'b111100;
    localparam logic [5:0] O_FLUSH = 6'b000001;

    typedef struct {
        string      name;
        logic [3:0] rn, rs, rm;
        logic [2:0] use_en;
        logic       valid, is_load;
        logic [3:0] rd;
        logic       req, ready, br;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ex_rn = 4'd0; ex_rs = 4'd0; ex_rm = 4'd0; ex_use = 3'b000;
        mem_valid = 1'b0; mem_is_load = 1'b0; mem_rd = 4'd0;
        mem_req = 1'b0; mem_ready = 1'b0; br_taken = 1'b0;
    endtask

    task automatic set_hazard();
        ex_rn = 4'd3; ex_use = 3'b001;
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd = 4'd3;
    endtask

    // Apply reset for one cycle; outputs must be 0 while rst is high.
    task automatic do_reset(input bit chk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        if (chk) begin
            check("reset_outs", 32'(outs), 32'(O_NONE));
            check("reset_cnt", 32'(stall_cnt), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Sample outputs mid-cycle, then advance past the next rising edge.
    task automatic cyc(input string name, input logic [5:0] exp);
        @(negedge clk);
        check(name, 32'(outs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] rn, rs, rm,
                                input logic [2:0] use_en, input logic valid, is_load,
                                input logic [3:0] rd, input logic req, ready, br,
                                input logic [5:0] exp);
        vec_t v;
        v.name = name; v.rn = rn; v.rs = rs; v.rm = rm; v.use_en = use_en;
        v.valid = valid; v.is_load = is_load; v.rd = rd;
        v.req = req; v.ready = ready; v.br = br; v.exp = exp;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        clear_inputs();

        //              name          rn     rs     rm     use     vld   ld    rd     req   rdy   br    exp
        vecs[0]  = mk("lu_rn",      4'd3,  4'd0,  4'd0,  3'b001, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, O_LOAD);
        vecs[1]  = mk("not_load",   4'd3,  4'd0,  4'd0,  3'b001, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, O_NONE);
        vecs[2]  = mk("rd_pc",      4'd15, 4'd0,  4'd0,  3'b001, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, O_NONE);
        vecs[3]  = mk("unused_op",  4'd3,  4'd0,  4'd0,  3'b000, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, O_NONE);
        vecs[4]  = mk("lu_rs",      4'd1,  4'd5,  4'd2,  3'b010, 1'b1, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, O_LOAD);
        vecs[5]  = mk("lu_rm",      4'd1,  4'd2,  4'd7,  3'b100, 1'b1, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, O_LOAD);
        vecs[6]  = mk("mem_wait",   4'd0,  4'd0,  4'd0,  3'b000, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, O_WAIT);
        vecs[7]  = mk("mem_ready",  4'd0,  4'd0,  4'd0,  3'b000, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, O_NONE);
        vecs[8]  = mk("branch",     4'd0,  4'd0,  4'd0,  3'b000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, O_FLUSH);
        vecs[9]  = mk("wait_br_lu", 4'd3,  4'd0,  4'd0,  3'b001, 1'b1, 1'b1, 4'd3,  1'b1, 1'b0, 1'b1, O_WAIT);
        vecs[10] = mk("br_over_lu", 4'd3,  4'd0,  4'd0,  3'b001, 1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b1, O_FLUSH);
        vecs[11] = mk("mem_invld",  4'd3,  4'd0,  4'd0,  3'b001, 1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, O_NONE);

        do_reset(1'b1);

        for (int i = 0; i < 12; i++) begin
            do_reset(1'b0);
            ex_rn = vecs[i].rn; ex_rs = vecs[i].rs; ex_rm = vecs[i].rm; ex_use = vecs[i].use_en;
            mem_valid = vecs[i].valid; mem_is_load = vecs[i].is_load; mem_rd = vecs[i].rd;
            mem_req = vecs[i].req; mem_ready = vecs[i].ready; br_taken = vecs[i].br;
            cyc(vecs[i].name, vecs[i].exp);
        end

        // Load-use: one bubble cycle, hazard masked in LOAD_STALL, then RUN.
        do_reset(1'b0);
        set_hazard();
        cyc("seq_lu_stall", O_LOAD);
        cyc("seq_lu_masked", O_NONE);
        clear_inputs();
        @(negedge clk);
        check("seq_lu_cnt", 32'(stall_cnt), 32'd1);
        cyc("seq_lu_run", O_NONE);

        // Memory wait: three stalled cycles, stalls drop on ready.
        do_reset(1'b0);
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("seq_wait", O_WAIT);
        mem_ready = 1'b1;
        @(negedge clk);
        check("seq_wait_cnt", 32'(stall_cnt), 32'd3);
        cyc("seq_wait_ready", O_NONE);

        // Branch: flush for two consecutive cycles, then back to RUN.
        do_reset(1'b0);
        br_taken = 1'b1;
        cyc("seq_br_0", O_FLUSH);
        br_taken = 1'b0;
        cyc("seq_br_1", O_FLUSH);
        cyc("seq_br_done", O_NONE);
        @(negedge clk);
        check("seq_br_cnt", 32'(stall_cnt), 32'd0);

        // Simultaneous wait, branch and load-use: stalls only, then a two-cycle flush.
        do_reset(1'b0);
        set_hazard();
        mem_req = 1'b1;
        br_taken = 1'b1;
        cyc("seq_sim_wait0", O_WAIT);
        cyc("seq_sim_wait1", O_WAIT);
        mem_ready = 1'b1;
        cyc("seq_sim_ready", O_FLUSH);
        br_taken = 1'b0;
        mem_req = 1'b0;
        cyc("seq_sim_flush", O_FLUSH);
        clear_inputs();
        cyc("seq_sim_run", O_NONE);

        // Reset while in FLUSH: outputs 0 during reset and no leftover flush afterwards.
        do_reset(1'b0);
        br_taken = 1'b1;
        cyc("seq_rst_br", O_FLUSH);
        br_taken = 1'b0;
        rst = 1'b1;
        cyc("seq_rst_during", O_NONE);
        rst = 1'b0;
        cyc("seq_rst_after", O_NONE);

        // Saturation: 20 stalled cycles on a 4-bit counter.
        do_reset(1'b0);
        mem_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("seq_sat_stall", 32'(outs), 32'(O_WAIT));
        check("seq_sat_cnt", 32'(stall_cnt), 32'd15);
        mem_ready = 1'b1;
        cyc("seq_sat_ready", O_NONE);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
